snake_fb_scheduler: RTL and testbench
=====================================

SNAKE_FB_SCHEDULER -- requirements
Module: snake_fb_scheduler

Interface
REQ-001 Parameter GRID_W, 60, playfield width in cells.
REQ-002 Parameter GRID_H, 40, playfield height in cells.
REQ-003 Parameter X_BITS, 6, cell x coordinate width.
REQ-004 Parameter Y_BITS, 6, cell y coordinate width.
REQ-005 Parameter S_LEN_W, 8, snake length width.
REQ-006 Parameter S_ADDR_W, 8, segment-store address width.
REQ-007 Parameter Q_TIMEOUT, 15, maximum cycles to wait for q_vld per segment.
REQ-008 Derived constant FB_AW = clog2(GRID_W*GRID_H), which is 12 for the defaults.
REQ-009 Reset is rst_n, asynchronous, active-low; the clock is px_clk.
REQ-010 Ports SHALL be, in order:
- px_clk in 1: clock.
- rst_n in 1: async active-low reset.
- frame_start in 1: one-cycle vblank-start pulse.
- state in 2: game state.
- len in S_LEN_W: snake length.
- hx/hy in X_BITS/Y_BITS: snake head cell.
- fx/fy in X_BITS/Y_BITS: food cell.
- q_req out 1: segment read request.
- q_addr out S_ADDR_W: segment index.
- q_vld in 1: segment data valid.
- q_x/q_y in X_BITS/Y_BITS: segment cell.
- fb_we out 1: framebuffer write enable.
- fb_waddr out FB_AW: framebuffer write address.
- fb_wdata out 3: cell code.
- busy out 1: rebuild in progress.
- done out 1: one-cycle completion pulse.
- overrun out 1: sticky error flag.

Function
REQ-011 Cell codes SHALL be EMPTY=0, BODY=1, HEAD=2, FOOD=3, TAIL=4.
REQ-012 The FSM SHALL have the states IDLE, CLEAR, SEG_REQ, SEG_WAIT, HEAD, FOOD, DONE.
REQ-013 In IDLE, a frame_start pulse SHALL latch state, len, hx, hy, fx and fy; all later stages SHALL use only these latched values; the FSM then enters CLEAR and busy asserts on the next cycle.
REQ-014 CLEAR SHALL write EMPTY to addresses 0..GRID_W*GRID_H-1, one per cycle, starting the cycle after frame_start, which takes 2400 cycles at the defaults.
REQ-015 After CLEAR, if the latched state is 00 or 11, the FSM SHALL go directly to DONE; otherwise it SHALL go to SEG_REQ with index 1.
REQ-016 In SEG_REQ, while index < len, the block SHALL assert q_req with q_addr=index and move to SEG_WAIT; if index >= len, it SHALL move to HEAD.
REQ-017 In SEG_WAIT, q_req and q_addr SHALL be held until q_vld is seen; on q_vld the block SHALL write TAIL if index == len-1 and BODY otherwise, to address q_y*GRID_W+q_x, then increment the index and return to SEG_REQ.
REQ-018 If q_vld is absent for Q_TIMEOUT cycles, the segment SHALL be skipped with no write, the index SHALL advance, and overrun SHALL NOT be set.
REQ-019 HEAD SHALL write HEAD at the latched hy*GRID_W+hx; FOOD SHALL then write FOOD at the latched fy*GRID_W+fx. Write order therefore gives HEAD priority over body and FOOD priority over all.
REQ-020 Any write with x >= GRID_W or y >= GRID_H SHALL be suppressed (fb_we stays 0), while the FSM still advances.
REQ-021 If len is 0 or 1, the segment phase SHALL be skipped entirely.
REQ-022 The address multiply SHALL be computed at FB_AW width with no truncation for any in-range coordinate.
REQ-023 DONE SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-024 A frame_start pulse while busy SHALL set overrun (sticky) and SHALL be ignored; the current rebuild continues.
REQ-025 fb_we SHALL be registered; fb_waddr and fb_wdata SHALL be valid in the same cycle as fb_we.

Reset
REQ-026 Reset SHALL clear the FSM to IDLE and drive all of the following to 0: q_req, q_addr, fb_we, fb_waddr, fb_wdata, busy, done, overrun, and the latched inputs.
REQ-027 Reset asserted mid-rebuild SHALL abort the rebuild immediately; there SHALL be no done pulse and no further writes until a new frame_start.

Configuration
REQ-028 With macro SNAKE_FB_SCHED_STATS_EN defined, the block SHALL add two 16-bit outputs:
- frame_cnt: incremented on each done pulse.
- skip_cnt: incremented on each timeout skip.
Both counters SHALL saturate and reset to 0.
REQ-029 Without SNAKE_FB_SCHED_STATS_EN, neither port nor counter SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-030 The cell-code constants and FSM state encodings SHALL reside in the shared package snake_pkg.
REQ-031 A single sub-module snake_fb_addr (registered computation of y*GRID_W+x, plus the range check) SHALL be instantiated for all address calculations.

Verification
REQ-032 Scenario 1: state=01, len=3, head (5,5), food (10,10), segments 1=(4,5) and 2=(3,5) with q_vld after 2 cycles. Required response: 2400 EMPTY writes, then BODY@304, TAIL@303, HEAD@305, FOOD@610, then done.
REQ-033 Scenario 2: state=00. Required response: CLEAR writes only, with done exactly 2401 cycles after frame_start.
REQ-034 Scenario 3: len=3 with q_vld never asserted. Required response: two timeout skips of 15 cycles each, no BODY/TAIL writes, HEAD and FOOD still written, overrun stays 0.
REQ-035 Scenario 4: a second frame_start during CLEAR. Required response: overrun=1, a single done pulse, and the write sequence unchanged.
REQ-036 Scenario 5: food at (60,2). Required response: no FOOD write and done is still asserted.
REQ-037 Scenario 6: rst_n low at CLEAR address 1000. Required response: all outputs 0 within the same cycle (asynchronous), and no done pulse.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: cell codes, scheduler FSM state encodings and the game-state
// helper shared by the framebuffer scheduler files.
package snake_pkg;
  typedef logic [2:0] cell_t;
  localparam cell_t C_EMPTY = 3'd0;
  localparam cell_t C_BODY  = 3'd1;
  localparam cell_t C_HEAD  = 3'd2;
  localparam cell_t C_FOOD  = 3'd3;
  localparam cell_t C_TAIL  = 3'd4;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_SEG_REQ  = 3'd2;
  localparam logic [2:0] S_SEG_WAIT = 3'd3;
  localparam logic [2:0] S_HEAD     = 3'd4;
  localparam logic [2:0] S_FOOD     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  // Only states 01 and 10 have a snake on screen.
  function automatic logic is_play(input logic [1:0] st);
    return st == 2'b01 || st == 2'b10;
  endfunction
endpackage

// File: rtl/snake_fb_addr.sv
// snake_fb_addr: registered cell-to-framebuffer address (y*GRID_W+x) with
// an off-grid check that suppresses the write enable.
module snake_fb_addr
  import snake_pkg::*;
#(
  parameter int GRID_W = 60,
  parameter int GRID_H = 40,
  parameter int X_BITS = 6,
  parameter int Y_BITS = 6,
  parameter int FB_AW  = 12
) (
  input  logic              px_clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [X_BITS-1:0] i_x,
  input  logic [Y_BITS-1:0] i_y,
  input  cell_t             i_code,
  output logic              o_we,
  output logic [FB_AW-1:0]  o_addr,
  output cell_t             o_code
);
  logic w_in_grid;
  assign w_in_grid = 32'(i_x) < GRID_W && 32'(i_y) < GRID_H;
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      o_we   <= 1'b0;
      o_addr <= '0;
      o_code <= C_EMPTY;
    end else begin
      o_we <= i_vld && w_in_grid;
      if (i_vld) begin
        o_addr <= FB_AW'(i_y) * FB_AW'(GRID_W) + FB_AW'(i_x);
        o_code <= i_code;
      end
    end
endmodule

// File: rtl/snake_fb_scheduler.sv
// snake_fb_scheduler: per-frame framebuffer rebuild (clear, body, head, food).
// Define SNAKE_FB_SCHED_STATS_EN to add saturating frame/skip counters.
module snake_fb_scheduler
  import snake_pkg::*;
#(
  parameter int GRID_W    = 60,
  parameter int GRID_H    = 40,
  parameter int X_BITS    = 6,
  parameter int Y_BITS    = 6,
  parameter int S_LEN_W   = 8,
  parameter int S_ADDR_W  = 8,
  parameter int Q_TIMEOUT = 15,
  localparam int FB_AW    = $clog2(GRID_W * GRID_H)
) (
  input  logic                px_clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [1:0]          state,
  input  logic [S_LEN_W-1:0]  len,
  input  logic [X_BITS-1:0]   hx,
  input  logic [Y_BITS-1:0]   hy,
  input  logic [X_BITS-1:0]   fx,
  input  logic [Y_BITS-1:0]   fy,
  output logic                q_req,
  output logic [S_ADDR_W-1:0] q_addr,
  input  logic                q_vld,
  input  logic [X_BITS-1:0]   q_x,
  input  logic [Y_BITS-1:0]   q_y,
  output logic                fb_we,
  output logic [FB_AW-1:0]    fb_waddr,
  output logic [2:0]          fb_wdata,
  output logic                busy,
  output logic                done,
  output logic                overrun
`ifdef SNAKE_FB_SCHED_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         skip_cnt
`endif
);
  localparam int T_W = $clog2(Q_TIMEOUT + 1);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(GRID_H - 1);
  localparam logic [T_W-1:0]    T_LAST = T_W'(Q_TIMEOUT - 1);
  logic [2:0]          r_fsm;
  logic [1:0]          r_state;
  logic [S_LEN_W-1:0]  r_len, r_idx;
  logic [X_BITS-1:0]   r_hx, r_fx, r_cx;
  logic [Y_BITS-1:0]   r_hy, r_fy, r_cy;
  logic [T_W-1:0]      r_tmr;
  logic                r_busy, r_done, r_overrun, r_q_req;
  logic [S_ADDR_W-1:0] r_q_addr;
  logic [2:0]          w_nxt;
  logic                w_accept, w_clr_end, w_skip, w_wr_vld;
  logic [X_BITS-1:0]   w_wr_x;
  logic [Y_BITS-1:0]   w_wr_y;
  cell_t               w_wr_code;
  assign w_accept  = frame_start && (r_fsm == S_IDLE || r_fsm == S_DONE);
  assign w_clr_end = r_cx == X_LAST && r_cy == Y_LAST;
  assign w_skip    = !q_vld && r_tmr == T_LAST;
  always_comb begin
    w_nxt = S_IDLE;
    case (r_fsm)
      S_IDLE, S_DONE: w_nxt = frame_start ? S_CLEAR : S_IDLE;
      S_CLEAR:        w_nxt = !w_clr_end ? S_CLEAR : is_play(r_state) ? S_SEG_REQ : S_DONE;
      S_SEG_REQ:      w_nxt = r_idx < r_len ? S_SEG_WAIT : S_HEAD;
      S_SEG_WAIT:     w_nxt = (q_vld || w_skip) ? S_SEG_REQ : S_SEG_WAIT;
      S_HEAD:         w_nxt = S_FOOD;
      S_FOOD:         w_nxt = S_DONE;
      default:        w_nxt = S_IDLE;
    endcase
  end
  // Every framebuffer write funnels through one address unit; later writes win.
  always_comb begin
    w_wr_vld  = 1'b0;
    w_wr_x    = r_cx;
    w_wr_y    = r_cy;
    w_wr_code = C_EMPTY;
    case (r_fsm)
      S_CLEAR: w_wr_vld = 1'b1;
      S_SEG_WAIT: begin
        w_wr_vld  = q_vld;
        w_wr_x    = q_x;
        w_wr_y    = q_y;
        w_wr_code = r_idx == r_len - S_LEN_W'(1) ? C_TAIL : C_BODY;
      end
      S_HEAD: begin
        w_wr_vld  = 1'b1;
        w_wr_x    = r_hx;
        w_wr_y    = r_hy;
        w_wr_code = C_HEAD;
      end
      S_FOOD: begin
        w_wr_vld  = 1'b1;
        w_wr_x    = r_fx;
        w_wr_y    = r_fy;
        w_wr_code = C_FOOD;
      end
      default: ;
    endcase
  end
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      r_fsm     <= S_IDLE;
      r_state   <= '0;
      r_len     <= '0;
      r_hx      <= '0;
      r_hy      <= '0;
      r_fx      <= '0;
      r_fy      <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_idx     <= '0;
      r_tmr     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_q_req   <= 1'b0;
      r_q_addr  <= '0;
    end else begin
      r_fsm  <= w_nxt;
      r_busy <= !(w_nxt == S_IDLE || w_nxt == S_DONE);
      r_done <= w_nxt == S_DONE;
      if (frame_start && r_busy) r_overrun <= 1'b1;
      if (w_accept) begin
        r_state <= state;
        r_len   <= len;
        r_hx    <= hx;
        r_hy    <= hy;
        r_fx    <= fx;
        r_fy    <= fy;
        r_cx    <= '0;
        r_cy    <= '0;
      end
      if (r_fsm == S_CLEAR) begin
        r_cx  <= r_cx == X_LAST ? '0 : r_cx + X_BITS'(1);
        r_cy  <= r_cx == X_LAST ? r_cy + Y_BITS'(1) : r_cy;
        r_idx <= S_LEN_W'(1);
      end
      if (r_fsm == S_SEG_REQ && w_nxt == S_SEG_WAIT) begin
        r_q_req  <= 1'b1;
        r_q_addr <= S_ADDR_W'(r_idx);
        r_tmr    <= '0;
      end
      if (r_fsm == S_SEG_WAIT) begin
        r_tmr <= r_tmr + T_W'(1);
        if (w_nxt == S_SEG_REQ) begin
          r_q_req <= 1'b0;
          r_idx   <= r_idx + S_LEN_W'(1);
        end
      end
    end
  snake_fb_addr #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_BITS(X_BITS), .Y_BITS(Y_BITS), .FB_AW(FB_AW)
  ) u_addr (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .i_vld  (w_wr_vld),
    .i_x    (w_wr_x),
    .i_y    (w_wr_y),
    .i_code (w_wr_code),
    .o_we   (fb_we),
    .o_addr (fb_waddr),
    .o_code (fb_wdata)
  );
  assign q_req   = r_q_req;
  assign q_addr  = r_q_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;
`ifdef SNAKE_FB_SCHED_STATS_EN
  logic [15:0] r_frame_cnt, r_skip_cnt;
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_skip_cnt  <= '0;
    end else begin
      if (r_done && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_fsm == S_SEG_WAIT && w_skip && r_skip_cnt != '1) r_skip_cnt <= r_skip_cnt + 16'd1;
    end
  assign frame_cnt = r_frame_cnt;
  assign skip_cnt  = r_skip_cnt;
`endif
endmodule

// File: tb/tb_snake_fb_scheduler.sv
// tb_snake_fb_scheduler: directed frames against hand-computed framebuffer
// write sequences, done latency, timeout skips, overrun and async reset.
module tb_snake_fb_scheduler;
  logic        px_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  state = '0;
  logic [7:0]  len = '0;
  logic [5:0]  hx = '0, hy = '0, fx = '0, fy = '0;
  logic        q_req;
  logic [7:0]  q_addr;
  logic        q_vld = 1'b0;
  logic [5:0]  q_x = '0, q_y = '0;
  logic        fb_we;
  logic [11:0] fb_waddr;
  logic [2:0]  fb_wdata;
  logic        busy, done, overrun;

  snake_fb_scheduler dut (
    .px_clk(px_clk), .rst_n(rst_n), .frame_start(frame_start), .state(state),
    .len(len), .hx(hx), .hy(hy), .fx(fx), .fy(fy),
    .q_req(q_req), .q_addr(q_addr), .q_vld(q_vld), .q_x(q_x), .q_y(q_y),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 px_clk = ~px_clk;

  int vec = 0, miss = 0;
  int ncyc = 0, fs_cyc = -1, done_cyc = -1, done_cnt = 0, qreq_cyc = 0;
  logic [11:0] wa[$];
  logic [2:0]  wd[$];
  logic        resp_en = 1'b0;
  logic        busy1;
  logic [5:0]  sx[0:3] = '{6'd0, 6'd4, 6'd3, 6'd0};
  logic [5:0]  sy[0:3] = '{6'd0, 6'd5, 6'd5, 6'd0};

  initial forever begin
    @(negedge px_clk);
    ncyc++;
    if (fb_we) begin
      wa.push_back(fb_waddr);
      wd.push_back(fb_wdata);
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = ncyc;
    end
    if (frame_start && fs_cyc < 0) fs_cyc = ncyc;
    if (q_req) qreq_cyc++;
  end

  // Segment store: answers a request two cycles after it appears.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge px_clk);
      #1;
      if (q_vld) begin
        q_vld = 1'b0;
        rcnt = 0;
      end else if (q_req && resp_en) begin
        rcnt++;
        if (rcnt == 2) begin
          q_vld = 1'b1;
          q_x = sx[q_addr[1:0]];
          q_y = sy[q_addr[1:0]];
        end
      end
    end
  end

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] st, input logic [7:0] ln,
                       input logic [5:0] ahx, input logic [5:0] ahy,
                       input logic [5:0] afx, input logic [5:0] afy);
    wa.delete();
    wd.delete();
    done_cnt = 0;
    qreq_cyc = 0;
    fs_cyc = -1;
    done_cyc = -1;
    state = st; len = ln; hx = ahx; hy = ahy; fx = afx; fy = afy;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    busy1 = busy;
    state = 2'b00; len = 8'd0; hx = 6'd0; hy = 6'd0; fx = 6'd0; fy = 6'd0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) tick();
  endtask

  task automatic chk_clear();
    int bad;
    bad = 0;
    for (int i = 0; i < 2400; i++)
      if (i >= wa.size() || wa[i] !== 12'(i) || wd[i] !== 3'd0) bad++;
    chk("clear_seq", bad, 0);
  endtask

  task automatic chk_wr(input string tag, input int i, input int a, input int d);
    chk(tag, (i < wa.size()) ? {17'd0, wa[i], wd[i]} : 32'hFFFF_FFFF, (a << 3) | d);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_waddr_wdata", {fb_waddr, fb_wdata}, 0);
    chk("rst_q_req_addr", {q_req, q_addr}, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    resp_en = 1'b1;
    start(2'b01, 8'd3, 6'd5, 6'd5, 6'd10, 6'd10);
    chk("s1_busy_next", busy1, 1);
    wait_done(3000);
    chk("s1_nwrites", wa.size(), 2404);
    chk_clear();
    chk_wr("s1_body", 2400, 304, 1);
    chk_wr("s1_tail", 2401, 303, 4);
    chk_wr("s1_head", 2402, 305, 2);
    chk_wr("s1_food", 2403, 610, 3);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_busy_after", busy, 0);
    chk("s1_overrun", overrun, 0);

    start(2'b00, 8'd3, 6'd5, 6'd5, 6'd10, 6'd10);
    wait_done(3000);
    chk("s2_nwrites", wa.size(), 2400);
    chk_clear();
    chk("s2_done_latency", done_cyc - fs_cyc, 2401);
    chk("s2_no_seg_req", qreq_cyc, 0);

    resp_en = 1'b0;
    start(2'b10, 8'd3, 6'd5, 6'd5, 6'd10, 6'd10);
    wait_done(3000);
    chk("s3_nwrites", wa.size(), 2402);
    chk_wr("s3_head", 2400, 305, 2);
    chk_wr("s3_food", 2401, 610, 3);
    chk("s3_req_cycles", qreq_cyc, 30);
    chk("s3_overrun", overrun, 0);

    resp_en = 1'b1;
    start(2'b01, 8'd3, 6'd5, 6'd5, 6'd10, 6'd10);
    repeat (100) tick();
    state = 2'b01; len = 8'd3; hx = 6'd1; hy = 6'd1; fx = 6'd2; fy = 6'd2;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("s4_overrun", overrun, 1);
    wait_done(3000);
    repeat (20) tick();
    chk("s4_done_cnt", done_cnt, 1);
    chk("s4_nwrites", wa.size(), 2404);
    chk_clear();
    chk_wr("s4_body", 2400, 304, 1);
    chk_wr("s4_tail", 2401, 303, 4);
    chk_wr("s4_head", 2402, 305, 2);
    chk_wr("s4_food", 2403, 610, 3);
    chk("s4_overrun_sticky", overrun, 1);

    start(2'b10, 8'd1, 6'd5, 6'd5, 6'd60, 6'd2);
    wait_done(3000);
    chk("s5_nwrites", wa.size(), 2401);
    chk_wr("s5_head", 2400, 305, 2);
    chk("s5_done_cnt", done_cnt, 1);
    chk("s5_len1_no_req", qreq_cyc, 0);

    start(2'b01, 8'd3, 6'd5, 6'd5, 6'd10, 6'd10);
    n = 0;
    while (!(fb_we && fb_waddr == 12'd1000) && n < 3000) begin
      tick();
      n++;
    end
    chk("s6_reached_1000", fb_waddr, 1000);
    rst_n = 1'b0;
    #1;
    chk("s6_fb_we", fb_we, 0);
    chk("s6_waddr_wdata", {fb_waddr, fb_wdata}, 0);
    chk("s6_busy_done", {busy, done}, 0);
    chk("s6_overrun", overrun, 0);
    tick();
    tick();
    rst_n = 1'b1;
    wa.delete();
    wd.delete();
    done_cnt = 0;
    repeat (3000) tick();
    chk("s6_no_writes", wa.size(), 0);
    chk("s6_no_done", done_cnt, 0);
    chk("s6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
